// File: rtl/broadcast_pkg.sv
// rtl/broadcast_pkg.sv - shared types and frame layout for the broadcast frame decoder
// Purpose: FSM state enum, default field widths and frame-field bit offsets
//          (offsets are measured from the start bit of a frame).
// Ports:   none (package).
package broadcast_pkg;

    localparam int ADDR_W  = 2;
    localparam int PORTS_N = 4;
    localparam int LEN_W   = 4;

    localparam int OFF_START   = 0;
    localparam int OFF_ADDR    = OFF_START + 1;
    localparam int OFF_MASK    = OFF_ADDR + ADDR_W;
    localparam int OFF_LEN     = OFF_MASK + PORTS_N;
    localparam int OFF_PAYLOAD = OFF_LEN + LEN_W;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MASK,
        LEN,
        PAYLOAD
    } state_t;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - loadable down-counter used for field bit counts and payload length
// Purpose: counts remaining bits of the current frame field.
// Ports:   clk, rst_n (async active-low), load_i/load_val_i (load has priority),
//          dec_i (decrement by one), value_o (current count), is_one_o (count == 1,
//          i.e. the bit being sampled now is the last of its field).
module bit_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] value_o,
    output logic         is_one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/broadcast_frame_decoder.sv
// rtl/broadcast_frame_decoder.sv - serial frame decoder feeding the multi-broadcaster
// Purpose: parses start | LB | PB[0..] | length | payload from rxBit and streams the
//          payload on serIn with LB/PB held. Every output is registered.
// Ports:   clk, rst_n (async active-low), rxBit (serial in, idle high),
//          serIn (payload bit), PB (port mask, zero unless outValid), LB (line select,
//          held until the next header completes), outValid, frameDone (pulse with the
//          last payload bit), busy (not IDLE).
module broadcast_frame_decoder #(
    parameter int LEN_W   = broadcast_pkg::LEN_W,
    parameter int ADDR_W  = broadcast_pkg::ADDR_W,
    parameter int PORTS_N = broadcast_pkg::PORTS_N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rxBit,
    output logic               serIn,
    output logic [0:PORTS_N-1] PB,
    output logic [ADDR_W-1:0]  LB,
    output logic               outValid,
    output logic               frameDone,
    output logic               busy
);

    import broadcast_pkg::*;

    // One extra bit so that length 0 can encode 2**LEN_W payload bits.
    localparam int CNT_W = LEN_W + 1;

    localparam logic [CNT_W-1:0] ADDR_CNT = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] MASK_CNT = CNT_W'(PORTS_N);
    localparam logic [CNT_W-1:0] LEN_CNT  = CNT_W'(LEN_W);
    localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(1 << LEN_W);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_sr_q;
    logic [0:PORTS_N-1]  mask_sr_q;
    logic [LEN_W-2:0]    len_sr_q;
    logic [ADDR_W-1:0]   lb_q;
    logic [0:PORTS_N-1]  mask_q;
    logic                serin_q;
    logic [0:PORTS_N-1]  pb_q;
    logic                valid_q;
    logic                done_q;
    logic                busy_q;

    logic                cnt_load;
    logic                cnt_dec;
    logic [CNT_W-1:0]    cnt_load_val;
    logic [CNT_W-1:0]    cnt_value;
    logic                cnt_is_one;
    logic [LEN_W-1:0]    len_next;

    // Length field including the bit being sampled this cycle.
    assign len_next = {len_sr_q, rxBit};

    // The counter is reloaded with the width of the next field on the last
    // bit of the current one, so every field ends on is_one.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            IDLE: begin
                if (!rxBit) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = ADDR_CNT;
                end
            end
            ADDR: begin
                if (cnt_is_one) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = MASK_CNT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MASK: begin
                if (cnt_is_one) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = LEN_CNT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LEN: begin
                if (cnt_is_one) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = (len_next == '0) ? MAX_LEN : {1'b0, len_next};
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            PAYLOAD: begin
                // Never wrap below zero; IDLE reloads before the count is used again.
                cnt_dec = (cnt_value != '0);
            end
            default: begin
                cnt_dec = 1'b0;
            end
        endcase
    end

    bit_counter #(
        .W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .value_o    (cnt_value),
        .is_one_o   (cnt_is_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_sr_q <= '0;
            mask_sr_q <= '0;
            len_sr_q  <= '0;
            lb_q      <= '0;
            mask_q    <= '0;
            serin_q   <= 1'b0;
            pb_q      <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            serin_q <= 1'b0;
            pb_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxBit) begin
                        state_q <= ADDR;
                        busy_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    addr_sr_q <= {addr_sr_q[ADDR_W-2:0], rxBit};
                    if (cnt_is_one) begin
                        state_q <= MASK;
                    end
                end
                MASK: begin
                    // PB[0] arrives first and ends up at index 0 after PORTS_N shifts.
                    mask_sr_q <= {mask_sr_q[1:PORTS_N-1], rxBit};
                    if (cnt_is_one) begin
                        state_q <= LEN;
                    end
                end
                LEN: begin
                    len_sr_q <= len_next[LEN_W-2:0];
                    if (cnt_is_one) begin
                        // Header complete: only now does the previous frame's LB change.
                        state_q <= PAYLOAD;
                        lb_q    <= addr_sr_q;
                        mask_q  <= mask_sr_q;
                    end
                end
                PAYLOAD: begin
                    if (mask_q != '0) begin
                        serin_q <= rxBit;
                        pb_q    <= mask_q;
                        valid_q <= 1'b1;
                    end
                    if (cnt_is_one) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign serIn     = serin_q;
    assign PB        = pb_q;
    assign LB        = lb_q;
    assign outValid  = valid_q;
    assign frameDone = done_q;
    assign busy      = busy_q;

endmodule
